// File: rtl/act_feeder_pkg.sv
// Shared types and helpers for the activation row feeder.
// Optional stall statistics are enabled with ACT_FEEDER_STAT_EN.
package act_feeder_pkg;

  localparam int N_ROW_DEF      = 3;
  localparam int WID_ACT_DEF    = 16;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int PEND_MAX_DEF   = 15;
  localparam int STALL_CNT_W    = 32;

  typedef logic [2*WID_ACT_DEF-1:0] act_word_t;

  function automatic int row_slice(
    input int ii,
    input int wid = WID_ACT_DEF
  );
    return ii * 2 * wid;
  endfunction

endpackage

// File: rtl/act_row_fifo.sv
// Per-row synchronous FIFO with extra wrap bit on each pointer.
// Flush empties the FIFO and wins over push and pop.
module act_row_fifo
  import act_feeder_pkg::*;
#(
  parameter int W     = $bits(act_word_t),
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign dout  = mem[rp[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full)
        wp <= wp + 1'b1;
      if (pop && !empty)
        rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !flush)
      mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/act_feeder_row.sv
// Activation feeder: shared write port, per-row FIFO, req credits, beats.
// Define ACT_FEEDER_STAT_EN to add per-row stall cycle counters.
module act_feeder_row
  import act_feeder_pkg::*;
#(
  parameter int N_ROW      = N_ROW_DEF,
  parameter int WID_ACT    = WID_ACT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int PEND_MAX   = PEND_MAX_DEF,
  parameter int WID_ROW    = (N_ROW > 1) ? $clog2(N_ROW) : 1
) (
  input  logic                       clk_l,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [2*WID_ACT-1:0]       wr_data,
  input  logic [WID_ROW-1:0]         wr_row,
  input  logic                       wr_vld,
  output logic                       wr_rdy,
  output logic [2*WID_ACT*N_ROW-1:0] act_data_in,
  output logic [N_ROW-1:0]           act_data_in_vld,
  input  logic [N_ROW-1:0]           act_data_in_req,
  output logic [N_ROW-1:0]           fifo_empty,
  output logic [N_ROW-1:0]           req_ovf
`ifdef ACT_FEEDER_STAT_EN
  ,
  output logic [STALL_CNT_W*N_ROW-1:0] stall_cnt
`endif
);

  localparam int DW = 2 * WID_ACT;
  localparam int PW = $clog2(PEND_MAX + 1);

  logic [N_ROW-1:0] full;

  // Out-of-range rows are accepted and dropped so a writer never hangs.
  always_comb begin
    wr_rdy = 1'b1;
    for (int ii = 0; ii < N_ROW; ii++)
      if (int'(wr_row) == ii)
        wr_rdy = !full[ii];
  end

  for (genvar gi = 0; gi < N_ROW; gi++) begin : g_row
    logic [PW-1:0] pend;
    logic [DW-1:0] dout;
    logic [DW-1:0] data_q;
    logic          vld_q;
    logic          ovf_q;
    logic          req;
    logic          push;
    logic          pop;
    logic          sat;

    assign req  = act_data_in_req[gi];
    assign sat  = (pend == PW'(PEND_MAX));
    assign push = wr_vld && !full[gi] &&
                  (int'(wr_row) == gi);
    // A req on this edge may be served on this edge.
    assign pop  = !flush && !fifo_empty[gi] &&
                  ((pend != '0) || req);

    act_row_fifo #(
      .W     (DW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk_l),
      .rst   (rst),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .din   (wr_data),
      .full  (full[gi]),
      .empty (fifo_empty[gi]),
      .dout  (dout)
    );

    always_ff @(posedge clk_l or posedge rst) begin
      if (rst) begin
        pend   <= '0;
        ovf_q  <= 1'b0;
        vld_q  <= 1'b0;
        data_q <= '0;
      end else if (flush) begin
        pend   <= '0;
        ovf_q  <= 1'b0;
        vld_q  <= 1'b0;
      end else begin
        pend  <= pend + PW'(req && !sat) - PW'(pop);
        vld_q <= pop;
        if (req && sat)
          ovf_q <= 1'b1;
        if (pop)
          data_q <= dout;
      end
    end

    assign act_data_in[row_slice(gi, WID_ACT) +: DW] = data_q;
    assign act_data_in_vld[gi] = vld_q;
    assign req_ovf[gi]         = ovf_q;

`ifdef ACT_FEEDER_STAT_EN
    logic [STALL_CNT_W-1:0] stall;

    always_ff @(posedge clk_l or posedge rst) begin
      if (rst)
        stall <= '0;
      else if (flush)
        stall <= '0;
      else if ((pend != '0) && fifo_empty[gi] && (stall != '1))
        stall <= stall + 1'b1;
    end

    assign stall_cnt[gi*STALL_CNT_W +: STALL_CNT_W] = stall;
`endif
  end

endmodule

// File: tb/tb_act_feeder_row.sv
// Directed bench for act_feeder_row with a queue-based reference model.
// Stall counter checks are active when ACT_FEEDER_STAT_EN is defined.
module tb_act_feeder_row;

  localparam int NR    = 3;
  localparam int DEPTH = 8;
  localparam int PMAX  = 15;

  logic        clk_l = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] wr_data;
  logic [1:0]  wr_row;
  logic        wr_vld;
  logic        wr_rdy;
  logic [95:0] act_data_in;
  logic [2:0]  vld;
  logic [2:0]  req;
  logic [2:0]  fifo_empty;
  logic [2:0]  req_ovf;
`ifdef ACT_FEEDER_STAT_EN
  logic [95:0] stall_cnt;
`endif

  act_feeder_row dut (
    .clk_l           (clk_l),
    .rst             (rst),
    .flush           (flush),
    .wr_data         (wr_data),
    .wr_row          (wr_row),
    .wr_vld          (wr_vld),
    .wr_rdy          (wr_rdy),
    .act_data_in     (act_data_in),
    .act_data_in_vld (vld),
    .act_data_in_req (req),
    .fifo_empty      (fifo_empty),
    .req_ovf         (req_ovf)
`ifdef ACT_FEEDER_STAT_EN
    ,
    .stall_cnt       (stall_cnt)
`endif
  );

  always #5 clk_l = ~clk_l;

  int vec = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got %0h want %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: word queues and credit integers per row.
  logic [31:0] mq [NR][$];
  int          mpend [NR];
  bit          movf [NR];
  bit          mvld [NR];
  logic [31:0] mdata [NR];
  longint      mstall [NR];
  bit          m_empty;
  bit          m_full;
  bit          m_srv;

  always @(posedge clk_l or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        mq[i].delete();
        mpend[i]  = 0;
        movf[i]   = 0;
        mvld[i]   = 0;
        mdata[i]  = '0;
        mstall[i] = 0;
      end
    end else begin
      for (int i = 0; i < NR; i++) begin
        m_empty = (mq[i].size() == 0);
        m_full  = (mq[i].size() == DEPTH);
        if (flush) begin
          mq[i].delete();
          mpend[i]  = 0;
          movf[i]   = 0;
          mvld[i]   = 0;
          mstall[i] = 0;
        end else begin
          if (mpend[i] > 0 && m_empty && mstall[i] < 64'hFFFF_FFFF)
            mstall[i]++;
          m_srv = !m_empty && (mpend[i] > 0 || req[i]);
          mvld[i] = m_srv;
          if (m_srv)
            mdata[i] = mq[i].pop_front();
          if (wr_vld && int'(wr_row) == i && !m_full)
            mq[i].push_back(wr_data);
          if (req[i]) begin
            if (mpend[i] == PMAX) movf[i] = 1;
            else mpend[i]++;
          end
          if (m_srv)
            mpend[i]--;
        end
      end
    end
  end

  function automatic bit exp_rdy();
    if (int'(wr_row) >= NR) return 1'b1;
    return mq[wr_row].size() != DEPTH;
  endfunction

  always @(negedge clk_l) begin
    if (!rst) begin
      for (int i = 0; i < NR; i++) begin
        chk($sformatf("m_vld%0d", i), vld[i], mvld[i]);
        chk($sformatf("m_data%0d", i), act_data_in[i*32 +: 32], mdata[i]);
        chk($sformatf("m_empty%0d", i), fifo_empty[i], mq[i].size() == 0);
        chk($sformatf("m_ovf%0d", i), req_ovf[i], movf[i]);
`ifdef ACT_FEEDER_STAT_EN
        chk($sformatf("m_stall%0d", i), stall_cnt[i*32 +: 32],
            mstall[i][31:0]);
`endif
      end
      chk("m_wr_rdy", wr_rdy, exp_rdy());
    end
  end

  task automatic tick();
    @(negedge clk_l);
    #1;
  endtask

  initial begin
    rst     = 1'b0;
    flush   = 1'b0;
    wr_data = '0;
    wr_row  = '0;
    wr_vld  = 1'b0;
    req     = '0;
    #2 rst  = 1'b1;
    @(negedge clk_l);
    chk("rst_vld", vld, 3'b000);
    chk("rst_data", act_data_in, 96'h0);
    chk("rst_empty", fifo_empty, 3'b111);
    chk("rst_ovf", req_ovf, 3'b000);
    #1 rst = 1'b0;
    #1 chk("rst_wr_rdy", wr_rdy, 1'b1);
    tick();

    // Single word then one req on row 1.
    wr_data = 32'hA5A5_0001; wr_row = 2'd1; wr_vld = 1'b1;
    tick();
    wr_vld = 1'b0; req = 3'b010;
    @(negedge clk_l);
    chk("t2_vld", vld, 3'b010);
    chk("t2_data", act_data_in[63:32], 32'hA5A5_0001);
    #1 req = '0;
    @(negedge clk_l);
    chk("t2_one_beat", vld, 3'b000);
    #1;

    // Credits first, data later on row 0.
    req = 3'b001;
    repeat (3) tick();
    req = '0;
    wr_row = 2'd0;
    for (int i = 0; i < 3; i++) begin
      wr_data = 32'hB000_0000 + 32'(i); wr_vld = 1'b1;
      @(negedge clk_l);
      chk("t3_vld", vld[0], i > 0);
      if (i > 0) chk("t3_data", act_data_in[31:0], 32'hB000_0000 + 32'(i - 1));
      #1;
    end
    wr_vld = 1'b0;
    @(negedge clk_l);
    chk("t3_vld_last", vld[0], 1'b1);
    chk("t3_data_last", act_data_in[31:0], 32'hB000_0002);
    #1;
    @(negedge clk_l);
    chk("t3_done", vld[0], 1'b0);
    #1;
    wr_data = 32'hB000_0003; wr_vld = 1'b1;
    tick();
    wr_vld = 1'b0;
    repeat (2) begin
      @(negedge clk_l);
      chk("t3_pend0", vld[0], 1'b0);
      #1;
    end
    chk("t3_held", fifo_empty[0], 1'b0);
    req = 3'b001;
    @(negedge clk_l);
    chk("t3_drain", act_data_in[31:0], 32'hB000_0003);
    #1 req = '0;

    // Fill row 2, then pop with a refused write.
    wr_row = 2'd2;
    for (int k = 0; k < 8; k++) begin
      wr_data = 32'h2000_0000 + 32'(k); wr_vld = 1'b1;
      tick();
    end
    wr_vld = 1'b0; wr_row = 2'd0;
    #1 chk("t4_rdy_row0", wr_rdy, 1'b1);
    wr_row = 2'd2;
    #1 chk("t4_rdy_row2", wr_rdy, 1'b0);
    wr_row = 2'd3;
    #1 chk("t4_rdy_row3", wr_rdy, 1'b1);
    wr_row = 2'd2; wr_data = 32'h2000_0099; wr_vld = 1'b1; req = 3'b100;
    @(negedge clk_l);
    chk("t4_vld", vld, 3'b100);
    chk("t4_data", act_data_in[95:64], 32'h2000_0000);
    #1 wr_vld = 1'b0;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk_l);
      chk("t4_drain", act_data_in[95:64], 32'h2000_0000 + 32'(k));
      #1;
    end
    req = '0;
    chk("t4_level7", fifo_empty[2], 1'b1);
    @(negedge clk_l);
    chk("t4_idle", vld[2], 1'b0);
    #1;

    // Credit saturation and flush.
    req = 3'b001;
    repeat (16) tick();
    req = '0;
    @(negedge clk_l);
    chk("t5_ovf", req_ovf, 3'b001);
    #1 flush = 1'b1;
    @(negedge clk_l);
    chk("t5_flush_ovf", req_ovf, 3'b000);
    chk("t5_flush_empty", fifo_empty, 3'b111);
    #1 flush = 1'b0;
    wr_row = 2'd0; wr_data = 32'hC0DE_0005; wr_vld = 1'b1;
    tick();
    wr_vld = 1'b0;
    repeat (2) begin
      @(negedge clk_l);
      chk("t5_pend0", vld[0], 1'b0);
      #1;
    end
    req = 3'b001;
    @(negedge clk_l);
    chk("t5_serve", act_data_in[31:0], 32'hC0DE_0005);
    #1 req = '0;
    tick();

`ifdef ACT_FEEDER_STAT_EN
    req = 3'b010;
    tick();
    req = '0;
    repeat (10) tick();
    chk("t6_stall", stall_cnt[63:32], 32'd10);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t6_clear", stall_cnt[63:32], 32'd0);
`endif

    // Reset in the middle of a beat, with a sticky overflow set.
    req = 3'b001;
    repeat (16) tick();
    req = '0;
    wr_row = 2'd1; wr_data = 32'h1111_2222; wr_vld = 1'b1;
    tick();
    wr_vld = 1'b0; req = 3'b010;
    @(negedge clk_l);
    chk("t1_pre_vld", vld, 3'b010);
    chk("t1_pre_ovf", req_ovf, 3'b001);
    #2 rst = 1'b1;
    req = '0;
    #1;
    chk("t1_vld", vld, 3'b000);
    chk("t1_data", act_data_in, 96'h0);
    chk("t1_empty", fifo_empty, 3'b111);
    chk("t1_ovf", req_ovf, 3'b000);
    @(negedge clk_l);
    #1 rst = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
